// File: rtl/alu_segmentada.sv
// Pipelined N-bit ALU: input register, PIPE internal stages, output register, valid/ready on both sides.
// Optional ALU_STICKY_FLAGS_EN adds limpiar_flags / flags_acum (sticky {desbordamiento, negativo, cero, carry}).
module alu_segmentada #(
  parameter int unsigned N    = 32,
  parameter int unsigned PIPE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] entrada1,
  input  logic [N-1:0] entrada2,
  input  logic [3:0]   selector,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultado,
  output logic         carry,
  output logic         cero,
  output logic         negativo,
  output logic         desbordamiento,
  output logic         op_invalida
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic         limpiar_flags,
  output logic [3:0]   flags_acum
`endif
);

  localparam int unsigned SHW    = $clog2(N);
  localparam int unsigned DEPTH  = PIPE + 1;
  localparam int unsigned PW     = N + 6;
  localparam int unsigned PIPE_W = DEPTH * PW;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;

  logic           adv;
  logic           v_in_q;
  logic [N-1:0]   a_q, b_q;
  logic [3:0]     sel_q;
  logic [PIPE_W-1:0] pipe_q;
  logic [PW-1:0]  out_stage;

  logic [N-1:0]   opb_d, res_d, sra_d;
  logic [SHW-1:0] sh_d;
  logic [N:0]     add_d, sub_d, sll_d, srl_d;
  logic           carry_d, ovf_d, inv_d, zero_d, neg_d;
  logic [PW-1:0]  stg_d;

  // Whole pipeline moves as one unit; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ALU evaluated on the input register; flags are born with the result.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    inv_d   = 1'b0;
    opb_d   = (sel_q == OP_INC || sel_q == OP_DEC) ? N'(1) : b_q;
    sh_d    = b_q[SHW-1:0];
    add_d   = {1'b0, a_q} + {1'b0, opb_d};
    sub_d   = {1'b0, a_q} - {1'b0, opb_d};
    sll_d   = {1'b0, a_q} << sh_d;
    srl_d   = {a_q, 1'b0} >> sh_d;
    sra_d   = $signed(a_q) >>> sh_d;
    case (sel_q)
      OP_ADD, OP_INC: begin
        res_d   = add_d[N-1:0];
        carry_d = add_d[N];
        ovf_d   = (a_q[N-1] == opb_d[N-1]) && (add_d[N-1] != a_q[N-1]);
      end
      OP_SUB, OP_DEC: begin
        res_d   = sub_d[N-1:0];
        carry_d = !sub_d[N];
        ovf_d   = (a_q[N-1] != opb_d[N-1]) && (sub_d[N-1] != a_q[N-1]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_NOT: res_d = ~a_q;
      OP_SLL: begin
        res_d   = sll_d[N-1:0];
        carry_d = sll_d[N];
      end
      OP_SRL: begin
        res_d   = srl_d[N:1];
        carry_d = srl_d[0];
      end
      OP_SRA: begin
        res_d   = sra_d;
        carry_d = srl_d[0];
      end
      default: inv_d = 1'b1;
    endcase
    zero_d = !inv_d && (res_d == '0);
    neg_d  = res_d[N-1];
    stg_d  = {v_in_q, inv_d, ovf_d, neg_d, zero_d, carry_d, res_d};
  end

  // Input register plus result shift chain; the oldest slot is the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_in_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      pipe_q <= '0;
    end else if (adv) begin
      v_in_q <= in_valid;
      a_q    <= entrada1;
      b_q    <= entrada2;
      sel_q  <= selector;
      pipe_q <= (pipe_q << PW) | PIPE_W'(stg_d);
    end
  end

  assign out_stage      = pipe_q[PIPE_W-1 -: PW];
  assign out_valid      = out_stage[N+5];
  assign op_invalida    = out_stage[N+4];
  assign desbordamiento = out_stage[N+3];
  assign negativo       = out_stage[N+2];
  assign cero           = out_stage[N+1];
  assign carry          = out_stage[N];
  assign resultado      = out_stage[N-1:0];

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] flags_acum_q;

  // Clear wins over a same-cycle accumulate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_acum_q <= '0;
    end else if (limpiar_flags) begin
      flags_acum_q <= '0;
    end else if (out_valid && out_ready) begin
      flags_acum_q <= flags_acum_q | {desbordamiento, negativo, cero, carry};
    end
  end

  assign flags_acum = flags_acum_q;
`endif

endmodule

// File: tb/tb_alu_segmentada.sv
// Randomized and directed bench for alu_segmentada (N=8, PIPE=1) with a scoreboard reference model.
module tb_alu_segmentada;

  localparam int unsigned N    = 8;
  localparam int unsigned PIPE = 1;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] entrada1;
  logic [N-1:0] entrada2;
  logic [3:0]   selector;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] resultado;
  logic         carry, cero, negativo, desbordamiento, op_invalida;
`ifdef ALU_STICKY_FLAGS_EN
  logic         limpiar_flags;
  logic [3:0]   flags_acum;
`endif

  alu_segmentada #(.N(N), .PIPE(PIPE)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .entrada1       (entrada1),
    .entrada2       (entrada2),
    .selector       (selector),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .resultado      (resultado),
    .carry          (carry),
    .cero           (cero),
    .negativo       (negativo),
    .desbordamiento (desbordamiento),
    .op_invalida    (op_invalida)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .limpiar_flags  (limpiar_flags),
    .flags_acum     (flags_acum)
`endif
  );

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       inv;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_out    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit operands.
  function automatic exp_t ref_alu(input int a, input int b, input int sel);
    exp_t e;
    int   sa, sb, r, sh, s;
    e  = '0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    r  = 0;
    case (sel)
      0:  begin r = a + b; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
      1:  begin r = a - b; e.c = (a >= b);  s = sa - sb; e.v = (s > 127) || (s < -128); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  begin r = a << sh;  e.c = (sh != 0) && (((a >> (8 - sh)) & 1) != 0); end
      7:  begin r = a >> sh;  e.c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      8:  begin r = sa >>> sh; e.c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      9:  begin r = a + 1; e.c = (a == 255); e.v = (sa == 127); end
      10: begin r = a - 1; e.c = (a != 0);   e.v = (sa == -128); end
      default: e.inv = 1'b1;
    endcase
    e.res = 8'(r & 255);
    e.z   = !e.inv && (e.res == 8'h00);
    e.n   = e.res[7];
    return e;
  endfunction

  // Scoreboard: observe handshakes mid-cycle, they complete on the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      q_exp.delete();
      n_acc = 0;
      n_out = 0;
    end else begin
      if (out_valid) begin
        if (q_exp.size() == 0) begin
          check_eq("out_unexpected", 32'(out_valid), 32'(0));
        end else begin
          check_eq("sb_resultado", 32'(resultado), 32'(q_exp[0].res));
          check_eq("sb_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}),
                   32'({q_exp[0].c, q_exp[0].z, q_exp[0].n, q_exp[0].v, q_exp[0].inv}));
          if (out_ready) begin
            void'(q_exp.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q_exp.push_back(ref_alu(int'(entrada1), int'(entrada2), int'(selector)));
        n_acc++;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    in_valid = 1'b1;
    entrada1 = a;
    entrada2 = b;
    selector = sel;
  endtask

  // Hold current beat until accepted, bounded.
  task automatic wait_accept(input string tag);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready;
      cyc();
    end
    if (!acc) check_eq(tag, 32'(0), 32'(1));
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q_exp.size() != 0; i++) cyc();
    cyc();
    check_eq(tag, 32'(q_exp.size()), 32'(0));
    check_eq({tag, "_count"}, 32'(n_out), 32'(n_acc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; entrada1 = '0; entrada2 = '0; selector = '0; out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
    limpiar_flags = 1'b0;
`endif
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_resultado", 32'(resultado), 32'(0));
    check_eq("rst_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(0));
    cyc();
    reset = 1'b1;
    cyc();
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));

    // Reset asserted mid-stream.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 8'($urandom), 4'(i));
      cyc();
    end
    reset = 1'b0;
    #2;
    check_eq("midrst_out_valid", 32'(out_valid), 32'(0));
    check_eq("midrst_resultado", 32'(resultado), 32'(0));
    check_eq("midrst_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(0));
    in_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check_eq("midrst_in_ready", 32'(in_ready), 32'(1));
    check_eq("midrst_empty", 32'(out_valid), 32'(0));

    // ADD overflow and latency.
    drive(8'h7F, 8'h01, 4'd0);
    cyc();
    in_valid = 1'b0;
    check_eq("lat_e0", 32'(out_valid), 32'(0));
    cyc();
    check_eq("lat_e1", 32'(out_valid), 32'(0));
    cyc();
    check_eq("lat_e2", 32'(out_valid), 32'(1));
    check_eq("add_res", 32'(resultado), 32'(8'h80));
    check_eq("add_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(5'b00110));
    cyc();

    // Back-to-back SUBs.
    drive(8'h05, 8'h05, 4'd1);
    cyc();
    drive(8'h03, 8'h05, 4'd1);
    cyc();
    in_valid = 1'b0;
    cyc();
    check_eq("sub0_valid", 32'(out_valid), 32'(1));
    check_eq("sub0_res", 32'(resultado), 32'(8'h00));
    check_eq("sub0_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(5'b11000));
    cyc();
    check_eq("sub1_valid", 32'(out_valid), 32'(1));
    check_eq("sub1_res", 32'(resultado), 32'(8'hFE));
    check_eq("sub1_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(5'b00100));
    cyc();

    // Shifts.
    drive(8'h81, 8'h01, 4'd6);
    cyc();
    drive(8'h80, 8'h03, 4'd8);
    cyc();
    in_valid = 1'b0;
    cyc();
    check_eq("sll_res", 32'(resultado), 32'(8'h02));
    check_eq("sll_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(5'b10000));
    cyc();
    check_eq("sra_res", 32'(resultado), 32'(8'hF0));
    check_eq("sra_flags", 32'({carry, cero, negativo, desbordamiento, op_invalida}), 32'(5'b00100));
    drain("dir_drain");

    // Backpressure with a full pipe; last beat uses a reserved code.
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 4'd0);
    cyc();
    drive(8'h33, 8'h0F, 4'd2);
    cyc();
    drive(8'hC3, 8'h00, 4'd5);
    cyc();
    drive(8'h5A, 8'hA5, 4'd13);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_in_ready", 32'(in_ready), 32'(0));
      cyc();
    end
    out_ready = 1'b1;
    wait_accept("stall_accept_timeout");
    drain("stall_drain");

    // Random traffic with random backpressure.
    drive(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 400; i++) begin
      logic acc;
      @(negedge clock);
      acc = in_valid && in_ready;
      cyc();
      if (acc || !in_valid) begin
        drive(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("rand_drain");

`ifdef ALU_STICKY_FLAGS_EN
    limpiar_flags = 1'b1;
    cyc();
    limpiar_flags = 1'b0;
    check_eq("sticky_clr0", 32'(flags_acum), 32'(0));
    drive(8'h7F, 8'h01, 4'd0);
    cyc();
    drive(8'h00, 8'h00, 4'd2);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check_eq("sticky_acc", 32'(flags_acum), 32'(4'b1110));
    limpiar_flags = 1'b1;
    cyc();
    limpiar_flags = 1'b0;
    check_eq("sticky_clr1", 32'(flags_acum), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
